// File: rtl/pkt_flow_stats.sv
// Per-flow packet/byte statistics sink with framing checks and saturating counters.
// Define PKT_FLOW_STATS_L1_BYTES_EN to add 24 bytes of L1 overhead (IFG/preamble + CRC) per packet.
module pkt_flow_stats #(
    parameter  int D_WIDTH     = 64,
    parameter  int EMPTY_WIDTH = 3,
    parameter  int FLOW_CNT    = 16,
    localparam int FLOW_W      = $clog2(FLOW_CNT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [D_WIDTH-1:0]     data,
    input  logic                   sop,
    input  logic                   eop,
    input  logic [EMPTY_WIDTH-1:0] empty,
    input  logic                   val,
    input  logic [FLOW_W-1:0]      flow_num,
    input  logic                   clr_stats,
    input  logic                   rd_en,
    input  logic [FLOW_W-1:0]      rd_flow,
    output logic                   rd_val,
    output logic [31:0]            rd_pkt_cnt,
    output logic [47:0]            rd_byte_cnt,
    output logic [15:0]            err_no_sop_cnt,
    output logic [15:0]            err_no_eop_cnt,
    output logic [15:0]            err_flow_cnt
);

    localparam logic [47:0]     BEAT_BYTES = 48'(D_WIDTH / 8);
    localparam logic [FLOW_W:0] FLOW_LIM   = (FLOW_W + 1)'(FLOW_CNT);
`ifdef PKT_FLOW_STATS_L1_BYTES_EN
    localparam logic [47:0]     L1_OVH     = 48'd24;
`else
    localparam logic [47:0]     L1_OVH     = 48'd0;
`endif

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    state_t              state_q, state_d;
    logic [FLOW_W-1:0]   flow_q, flow_d;
    logic                bad_q, bad_d;
    logic [47:0]         acc_q, acc_d;
    logic                commit_q, commit_d;
    logic [FLOW_W-1:0]   cflow_q, cflow_d;
    logic [47:0]         cbytes_q, cbytes_d;

    logic                inc_no_sop, inc_no_eop, inc_flow;
    logic [47:0]         beat_bytes;
    logic                flow_oor;

    logic [31:0]         pkt_cnt_q  [FLOW_CNT];
    logic [47:0]         byte_cnt_q [FLOW_CNT];
    logic [15:0]         err_no_sop_q, err_no_eop_q, err_flow_q;
    logic                rd_val_q;
    logic [31:0]         rd_pkt_q;
    logic [47:0]         rd_byte_q;

    logic                data_unused;
    assign data_unused = ^data;

    function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [47:0] b);
        logic [48:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[48] ? '1 : s[47:0];
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] a);
        return (a == '1) ? a : a + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        return (a == '1) ? a : a + 16'd1;
    endfunction

    always_comb begin
        beat_bytes = BEAT_BYTES;
        if (eop) begin
            beat_bytes = (48'(empty) >= BEAT_BYTES) ? '0 : BEAT_BYTES - 48'(empty);
        end
    end

    assign flow_oor = ({1'b0, flow_num} >= FLOW_LIM);

    // A sop beat always starts a fresh packet; in IN_PKT it first abandons the open one.
    always_comb begin
        state_d    = state_q;
        flow_d     = flow_q;
        bad_d      = bad_q;
        acc_d      = acc_q;
        commit_d   = 1'b0;
        cflow_d    = cflow_q;
        cbytes_d   = cbytes_q;
        inc_no_sop = 1'b0;
        inc_no_eop = 1'b0;
        inc_flow   = 1'b0;
        if (val) begin
            if (sop) begin
                inc_no_eop = (state_q == IN_PKT);
                inc_flow   = flow_oor;
                if (eop) begin
                    commit_d = !flow_oor;
                    cflow_d  = flow_num;
                    cbytes_d = beat_bytes;
                    acc_d    = '0;
                    state_d  = IDLE;
                end else begin
                    flow_d  = flow_num;
                    bad_d   = flow_oor;
                    acc_d   = beat_bytes;
                    state_d = IN_PKT;
                end
            end else if (state_q == IDLE) begin
                inc_no_sop = 1'b1;
            end else begin
                inc_flow = (flow_num != flow_q);
                acc_d    = sat_add48(acc_q, beat_bytes);
                if (eop) begin
                    commit_d = !bad_q;
                    cflow_d  = flow_q;
                    cbytes_d = sat_add48(acc_q, beat_bytes);
                    acc_d    = '0;
                    state_d  = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            flow_q   <= '0;
            bad_q    <= 1'b0;
            acc_q    <= '0;
            commit_q <= 1'b0;
            cflow_q  <= '0;
            cbytes_q <= '0;
        end else begin
            state_q  <= state_d;
            flow_q   <= flow_d;
            bad_q    <= bad_d;
            acc_q    <= acc_d;
            commit_q <= commit_d;
            cflow_q  <= cflow_d;
            cbytes_q <= cbytes_d;
        end
    end

    // Clear takes priority over the commit landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FLOW_CNT; i++) begin
                pkt_cnt_q[i]  <= '0;
                byte_cnt_q[i] <= '0;
            end
        end else if (clr_stats) begin
            for (int unsigned i = 0; i < FLOW_CNT; i++) begin
                pkt_cnt_q[i]  <= '0;
                byte_cnt_q[i] <= '0;
            end
        end else if (commit_q) begin
            pkt_cnt_q[cflow_q]  <= sat_inc32(pkt_cnt_q[cflow_q]);
            byte_cnt_q[cflow_q] <= sat_add48(byte_cnt_q[cflow_q], sat_add48(cbytes_q, L1_OVH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_no_sop_q <= '0;
            err_no_eop_q <= '0;
            err_flow_q   <= '0;
        end else if (clr_stats) begin
            err_no_sop_q <= '0;
            err_no_eop_q <= '0;
            err_flow_q   <= '0;
        end else begin
            if (inc_no_sop) err_no_sop_q <= sat_inc16(err_no_sop_q);
            if (inc_no_eop) err_no_eop_q <= sat_inc16(err_no_eop_q);
            if (inc_flow)   err_flow_q   <= sat_inc16(err_flow_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_val_q  <= 1'b0;
            rd_pkt_q  <= '0;
            rd_byte_q <= '0;
        end else begin
            rd_val_q <= rd_en;
            if (rd_en) begin
                if ({1'b0, rd_flow} < FLOW_LIM) begin
                    rd_pkt_q  <= pkt_cnt_q[rd_flow];
                    rd_byte_q <= byte_cnt_q[rd_flow];
                end else begin
                    rd_pkt_q  <= '0;
                    rd_byte_q <= '0;
                end
            end
        end
    end

    assign rd_val         = rd_val_q;
    assign rd_pkt_cnt     = rd_pkt_q;
    assign rd_byte_cnt    = rd_byte_q;
    assign err_no_sop_cnt = err_no_sop_q;
    assign err_no_eop_cnt = err_no_eop_q;
    assign err_flow_cnt   = err_flow_q;

endmodule

// File: doc/pkt_flow_stats.md
PKT_FLOW_STATS -- requirements
Module: pkt_flow_stats

Interface
REQ-001 Parameter D_WIDTH, default 64, data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter EMPTY_WIDTH, default 3, width of empty.
REQ-003 Parameter FLOW_CNT, default 16, number of flows tracked; FLOW_W = $clog2(FLOW_CNT).
REQ-004 Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- data, in, D_WIDTH: packet data; ignored except for width.
- sop, in, 1: start of packet.
- eop, in, 1: end of packet.
- empty, in, EMPTY_WIDTH: unused bytes on the eop beat.
- val, in, 1: beat valid.
- flow_num, in, FLOW_W: flow of the beat.
- clr_stats, in, 1: synchronous clear pulse.
- rd_en, in, 1: statistics read request.
- rd_flow, in, FLOW_W: flow to read.
- rd_val, out, 1: read data valid.
- rd_pkt_cnt, out, 32: packets in the flow.
- rd_byte_cnt, out, 48: bytes in the flow.
- err_no_sop_cnt, out, 16: protocol error count.
- err_no_eop_cnt, out, 16: protocol error count.
- err_flow_cnt, out, 16: protocol error count.

Function
REQ-005 Block is a pure sink: it SHALL never backpressure; every val beat SHALL be consumed in its cycle.
REQ-006 Framing FSM, states IDLE and IN_PKT; only val=1 beats SHALL cause transitions.
- IDLE + sop&eop: single-beat packet, commit, stay IDLE.
- IDLE + sop&!eop: latch flow_num, go IN_PKT.
- IDLE + !sop: err_no_sop, beat dropped, stay IDLE.
- IN_PKT + eop&!sop: commit, go IDLE.
- IN_PKT + sop: err_no_eop, open packet discarded uncommitted, new packet starts per IDLE rules.
REQ-007 Beat bytes SHALL be D_WIDTH/8 on non-eop beats and D_WIDTH/8 - empty on eop beats; an in-progress byte accumulator SHALL sum the bytes of the open packet.
REQ-008 In IN_PKT, a beat whose flow_num differs from the latched flow SHALL increment err_flow_cnt; its bytes SHALL still count toward the latched flow.
REQ-009 Commit SHALL occur on the cycle after the eop beat:
- pkt_cnt[flow] += 1.
- byte_cnt[flow] += packet bytes.
REQ-010 Counters SHALL saturate at all-ones and never wrap: per-flow counters and the three error counters.
REQ-011 Reads:
- rd_en at cycle N SHALL give rd_val=1 plus counters of rd_flow at N+1.
- rd_val SHALL be 0 otherwise.
- Read and commit to the same flow in one cycle SHALL return the pre-commit value.
REQ-012 clr_stats SHALL zero all per-flow and error counters on the next edge and SHALL override a same-cycle commit.
- The FSM state and any open packet are unaffected.
- A packet spanning the clear SHALL commit its full bytes afterwards.
REQ-013 An out-of-range flow_num (>= FLOW_CNT) SHALL be counted as err_flow and its packet SHALL not be committed.

Reset
REQ-014 rst_n low SHALL asynchronously force:
- FSM to IDLE.
- Accumulator, all counters, rd_val and rd_* data to 0.
REQ-015 Reset mid-packet SHALL discard the open packet; after release, beats SHALL be handled from IDLE.

Configuration
REQ-016 Macro PKT_FLOW_STATS_L1_BYTES_EN.
- Defined: each commit SHALL add packet bytes + 24 to byte_cnt (20 IFG/preamble + 4 CRC).
- Undefined: only payload bytes per REQ-007 SHALL be added.

Verification
REQ-017 Bench SHALL cover these directed scenarios:
- 3-beat packet, flow 5, empty=3, macro off -> flow 5 reads pkt=1, bytes=21; macro on -> bytes=45.
- Single-beat sop&eop, flow 0, empty=0, repeated 4 times back-to-back -> pkt=4, bytes=32, no errors.
- Beat without sop in IDLE, then sop in IN_PKT without eop -> err_no_sop_cnt=1, err_no_eop_cnt=1; discarded packet not counted.
- flow_num changes 2 to 7 mid-packet -> err_flow_cnt=1; bytes credited to flow 2; flow 7 = 0.
- rd_en for flow 3 on the commit cycle of a flow-3 packet -> old value returned; re-read next cycle -> new value.
- clr_stats on the eop-commit cycle, then rst_n pulse mid-packet -> counters 0; next clean packet counts normally.
